// File: rtl/snake_pkg.sv
// Shared Snake game types: direction codes, game state encoding and
// the direction-reversal helper used by the body tracker and the keyboard decoder.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_UP    = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } state_e;

  // Opposite directions share the axis bit and differ in the sign bit.
  function automatic logic is_reversal(input dir_e cur_d, input dir_e req_d);
    return (cur_d[1] == req_d[1]) && (cur_d[0] != req_d[0]);
  endfunction

endpackage

// File: rtl/snake_next_head.sv
// Combinational next-head calculator: one cell in dir from the head, with
// edge wrap or wall detection. Also used by the food-placement checker.
module snake_next_head
  import snake_pkg::*;
#(
  parameter int XW    = 8,
  parameter int YW    = 7,
  parameter int X_MAX = 159,
  parameter int Y_MAX = 119,
  parameter int WRAP  = 0
) (
  input  logic [XW-1:0] head_x,
  input  logic [YW-1:0] head_y,
  input  logic [1:0]    dir,
  output logic [XW-1:0] nh_x,
  output logic [YW-1:0] nh_y,
  output logic          wall
);

  localparam logic [XW:0] X_LIM   = (XW+1)'(X_MAX);
  localparam logic [YW:0] Y_LIM   = (YW+1)'(Y_MAX);
  localparam logic        WRAP_EN = (WRAP != 0);

  logic [XW:0] x_step_s;
  logic [YW:0] y_step_s;
  logic        x_under_s, x_over_s, y_under_s, y_over_s;

  // One-bit-wider step so underflow and overflow are visible before truncation.
  always_comb begin
    x_step_s = {1'b0, head_x};
    y_step_s = {1'b0, head_y};
    case (dir)
      DIR_RIGHT: x_step_s = {1'b0, head_x} + (XW+1)'(1);
      DIR_LEFT:  x_step_s = {1'b0, head_x} - (XW+1)'(1);
      DIR_DOWN:  y_step_s = {1'b0, head_y} + (YW+1)'(1);
      DIR_UP:    y_step_s = {1'b0, head_y} - (YW+1)'(1);
      default: begin
        x_step_s = {1'b0, head_x};
        y_step_s = {1'b0, head_y};
      end
    endcase
    x_under_s = (dir == DIR_LEFT)  && x_step_s[XW];
    x_over_s  = (dir == DIR_RIGHT) && (x_step_s > X_LIM);
    y_under_s = (dir == DIR_UP)    && y_step_s[YW];
    y_over_s  = (dir == DIR_DOWN)  && (y_step_s > Y_LIM);
  end

  // Resolve edge crossings into a wrapped coordinate or a wall flag.
  always_comb begin
    nh_x = x_step_s[XW-1:0];
    nh_y = y_step_s[YW-1:0];
    wall = 1'b0;
    if (x_under_s) begin
      nh_x = WRAP_EN ? XW'(X_MAX) : head_x;
      wall = !WRAP_EN;
    end else if (x_over_s) begin
      nh_x = WRAP_EN ? {XW{1'b0}} : head_x;
      wall = !WRAP_EN;
    end else if (y_under_s) begin
      nh_y = WRAP_EN ? YW'(Y_MAX) : head_y;
      wall = !WRAP_EN;
    end else if (y_over_s) begin
      nh_y = WRAP_EN ? {YW{1'b0}} : head_y;
      wall = !WRAP_EN;
    end else begin
      wall = 1'b0;
    end
  end

endmodule

// File: rtl/snake_body_tracker.sv
// Snake body store and mover: register-array body, per-step head advance,
// growth, wall/self collision detection and a registered indexed read port.
module snake_body_tracker
  import snake_pkg::*;
#(
  parameter int XW       = 8,
  parameter int YW       = 7,
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 3,
  parameter int X_MAX    = 159,
  parameter int Y_MAX    = 119,
  parameter int X0       = 80,
  parameter int Y0       = 60,
  parameter int WRAP     = 0
) (
  input  logic                         Clock,
  input  logic                         Resetn,
  input  logic                         start,
  input  logic                         step,
  input  logic [1:0]                   dir,
  input  logic                         grow,
  output logic [XW-1:0]                head_x,
  output logic [YW-1:0]                head_y,
  output logic [$clog2(MAX_LEN+1)-1:0] length,
  input  logic [$clog2(MAX_LEN)-1:0]   rd_idx,
  output logic [XW-1:0]                rd_x,
  output logic [YW-1:0]                rd_y,
  output logic                         rd_valid,
  output logic                         running,
  output logic                         dead,
  output logic                         wall_hit,
  output logic                         self_hit
);

  localparam int LW = $clog2(MAX_LEN+1);
  localparam int IW = $clog2(MAX_LEN);

  state_e        state_r, state_nx_s;
  dir_e          dir_r;
  logic          grow_pend_r;
  logic [XW-1:0] seg_x_r [MAX_LEN];
  logic [YW-1:0] seg_y_r [MAX_LEN];
  logic [LW-1:0] length_r;
  logic          wall_hit_r, self_hit_r, running_r, dead_r;
  logic [XW-1:0] rd_x_r;
  logic [YW-1:0] rd_y_r;
  logic          rd_valid_r;

  logic [XW-1:0] nh_x_s;
  logic [YW-1:0] nh_y_s;
  logic          wall_s, body_hit_s, self_s, hit_s;
  logic          move_s, grow_now_s, restart_s;
  logic [XW-1:0] rd_sel_x_s;
  logic [YW-1:0] rd_sel_y_s;

  snake_next_head #(
    .XW(XW), .YW(YW), .X_MAX(X_MAX), .Y_MAX(Y_MAX), .WRAP(WRAP)
  ) u_next_head (
    .head_x (seg_x_r[0]),
    .head_y (seg_y_r[0]),
    .dir    (dir_r),
    .nh_x   (nh_x_s),
    .nh_y   (nh_y_s),
    .wall   (wall_s)
  );

  // Parallel collision compare; the tail cell is free unless this move grows.
  always_comb begin
    move_s     = (state_r == ST_RUN) && step;
    restart_s  = (state_r == ST_DEAD) && start;
    grow_now_s = (grow_pend_r || grow) && (length_r < LW'(MAX_LEN));
    body_hit_s = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      body_hit_s = body_hit_s |
                   ((LW'(i) < length_r) &&
                    ((LW'(i) != (length_r - LW'(1))) || grow_now_s) &&
                    (seg_x_r[i] == nh_x_s) && (seg_y_r[i] == nh_y_s));
    end
    self_s = !wall_s && body_hit_s;
    hit_s  = wall_s || self_s;
  end

  // Read-port mux over the body array.
  always_comb begin
    rd_sel_x_s = {XW{1'b0}};
    rd_sel_y_s = {YW{1'b0}};
    for (int i = 0; i < MAX_LEN; i++) begin
      rd_sel_x_s = (rd_idx == IW'(i)) ? seg_x_r[i] : rd_sel_x_s;
      rd_sel_y_s = (rd_idx == IW'(i)) ? seg_y_r[i] : rd_sel_y_s;
    end
  end

  // Game state next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: state_nx_s = start ? ST_RUN : ST_IDLE;
      ST_RUN:  state_nx_s = (move_s && hit_s) ? ST_DEAD : ST_RUN;
      ST_DEAD: state_nx_s = start ? ST_IDLE : ST_DEAD;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Game state register.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Body array and length: reinitialise, or shift on a collision-free move.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_r[i] <= (i < INIT_LEN) ? XW'(X0 - i) : {XW{1'b0}};
        seg_y_r[i] <= (i < INIT_LEN) ? YW'(Y0) : {YW{1'b0}};
      end
      length_r <= LW'(INIT_LEN);
    end else if (restart_s) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_r[i] <= (i < INIT_LEN) ? XW'(X0 - i) : {XW{1'b0}};
        seg_y_r[i] <= (i < INIT_LEN) ? YW'(Y0) : {YW{1'b0}};
      end
      length_r <= LW'(INIT_LEN);
    end else if (move_s && !hit_s) begin
      seg_x_r[0] <= nh_x_s;
      seg_y_r[0] <= nh_y_s;
      for (int i = 1; i < MAX_LEN; i++) begin
        seg_x_r[i] <= seg_x_r[i-1];
        seg_y_r[i] <= seg_y_r[i-1];
      end
      if (grow_now_s) begin
        length_r <= length_r + LW'(1);
      end
    end
  end

  // Direction latch, pending growth and sticky collision causes.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      dir_r       <= DIR_RIGHT;
      grow_pend_r <= 1'b0;
      wall_hit_r  <= 1'b0;
      self_hit_r  <= 1'b0;
    end else if (restart_s) begin
      dir_r       <= DIR_RIGHT;
      grow_pend_r <= 1'b0;
      wall_hit_r  <= 1'b0;
      self_hit_r  <= 1'b0;
    end else begin
      if ((state_r == ST_RUN) && !is_reversal(dir_r, dir_e'(dir))) begin
        dir_r <= dir_e'(dir);
      end
      if (move_s) begin
        grow_pend_r <= 1'b0;
      end else if (grow && (state_r != ST_DEAD)) begin
        grow_pend_r <= 1'b1;
      end
      if (move_s && wall_s) begin
        wall_hit_r <= 1'b1;
      end
      if (move_s && self_s) begin
        self_hit_r <= 1'b1;
      end
    end
  end

  // Registered read port and state decode outputs.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      rd_x_r     <= {XW{1'b0}};
      rd_y_r     <= {YW{1'b0}};
      rd_valid_r <= 1'b0;
      running_r  <= 1'b0;
      dead_r     <= 1'b0;
    end else begin
      if (restart_s) begin
        rd_x_r     <= {XW{1'b0}};
        rd_y_r     <= {YW{1'b0}};
        rd_valid_r <= 1'b0;
      end else begin
        rd_x_r     <= rd_sel_x_s;
        rd_y_r     <= rd_sel_y_s;
        rd_valid_r <= (LW'(rd_idx) < length_r);
      end
      running_r <= (state_nx_s == ST_RUN);
      dead_r    <= (state_nx_s == ST_DEAD);
    end
  end

  assign head_x   = seg_x_r[0];
  assign head_y   = seg_y_r[0];
  assign length   = length_r;
  assign rd_x     = rd_x_r;
  assign rd_y     = rd_y_r;
  assign rd_valid = rd_valid_r;
  assign running  = running_r;
  assign dead     = dead_r;
  assign wall_hit = wall_hit_r;
  assign self_hit = self_hit_r;

endmodule

// File: tb/tb_snake_body_tracker.sv
// Scoreboard bench for snake_body_tracker: a WRAP=0 and a WRAP=1 instance share
// stimulus; a list-based reference model queues expectations for a monitor.
module tb_snake_body_tracker;

  localparam int XW = 8, YW = 7, ML = 16, IL = 3;
  localparam int XM = 159, YM = 119, X0 = 80, Y0 = 60;

  logic       Clock = 1'b0, Resetn = 1'b0;
  logic       start = 1'b0, step = 1'b0, grow = 1'b0;
  logic [1:0] dir = 2'd0;
  logic [3:0] rd_idx = 4'd0;

  logic [XW-1:0] hx0, hx1, rdx0, rdx1;
  logic [YW-1:0] hy0, hy1, rdy0, rdy1;
  logic [4:0]    len0, len1;
  logic          rdv0, rdv1, run0, run1, dead0, dead1, wh0, wh1, sh0, sh1;

  int checks = 0, errors = 0;

  snake_body_tracker #(.WRAP(0)) u0 (
    .Clock(Clock), .Resetn(Resetn), .start(start), .step(step), .dir(dir), .grow(grow),
    .head_x(hx0), .head_y(hy0), .length(len0), .rd_idx(rd_idx), .rd_x(rdx0), .rd_y(rdy0),
    .rd_valid(rdv0), .running(run0), .dead(dead0), .wall_hit(wh0), .self_hit(sh0));

  snake_body_tracker #(.WRAP(1)) u1 (
    .Clock(Clock), .Resetn(Resetn), .start(start), .step(step), .dir(dir), .grow(grow),
    .head_x(hx1), .head_y(hy1), .length(len1), .rd_idx(rd_idx), .rd_x(rdx1), .rd_y(rdy1),
    .rd_valid(rdv1), .running(run1), .dead(dead1), .wall_hit(wh1), .self_hit(sh1));

  always #5 Clock = ~Clock;

  typedef struct {
    int hx; int hy; int len; int run; int dead; int wh; int sh; int rdx; int rdy; int rdv;
  } obs_t;

  obs_t exp_q0[$];
  obs_t exp_q1[$];

  // Reference model: body positions as plain lists, state as 0 idle / 1 run / 2 dead.
  int mx[2][ML];
  int my[2][ML];
  int mlen[2], mst[2], mdir[2], mpend[2], mwh[2], msh[2], mrdx[2], mrdy[2], mrdv[2];

  function automatic int opp(input int d);
    case (d)
      0: return 1;
      1: return 0;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic void m_reset(input int k);
    for (int i = 0; i < ML; i++) begin
      mx[k][i] = (i < IL) ? X0 - i : 0;
      my[k][i] = (i < IL) ? Y0 : 0;
    end
    mlen[k] = IL; mst[k] = 0; mdir[k] = 0; mpend[k] = 0;
    mwh[k] = 0; msh[k] = 0; mrdx[k] = 0; mrdy[k] = 0; mrdv[k] = 0;
  endfunction

  function automatic void m_edge(input int k, input bit wrap, input bit s, input bit st,
                                 input int d, input bit g, input int ri);
    int nx, ny, growing, wall, hit;
    mrdx[k] = mx[k][ri]; mrdy[k] = my[k][ri]; mrdv[k] = (ri < mlen[k]) ? 1 : 0;
    case (mst[k])
      0: begin
        if (g) mpend[k] = 1;
        if (s) mst[k] = 1;
      end
      1: begin
        if (st) begin
          nx = mx[k][0] + ((mdir[k] == 0) ? 1 : (mdir[k] == 1) ? -1 : 0);
          ny = my[k][0] + ((mdir[k] == 2) ? 1 : (mdir[k] == 3) ? -1 : 0);
          wall = 0;
          if (nx < 0)  begin if (wrap) nx = XM; else wall = 1; end
          if (nx > XM) begin if (wrap) nx = 0;  else wall = 1; end
          if (ny < 0)  begin if (wrap) ny = YM; else wall = 1; end
          if (ny > YM) begin if (wrap) ny = 0;  else wall = 1; end
          growing = ((mpend[k] != 0 || g) && mlen[k] < ML) ? 1 : 0;
          hit = wall;
          if (wall == 0)
            for (int i = 0; i < mlen[k]; i++)
              if ((i != mlen[k] - 1 || growing != 0) && mx[k][i] == nx && my[k][i] == ny) hit = 1;
          if (hit != 0) begin
            if (wall != 0) mwh[k] = 1; else msh[k] = 1;
            mst[k] = 2;
          end else begin
            for (int i = ML - 1; i > 0; i--) begin
              mx[k][i] = mx[k][i-1]; my[k][i] = my[k][i-1];
            end
            mx[k][0] = nx; my[k][0] = ny;
            if (growing != 0) mlen[k]++;
          end
          mpend[k] = 0;
        end else if (g) begin
          mpend[k] = 1;
        end
        if (d != opp(mdir[k])) mdir[k] = d;
      end
      default: if (s) m_reset(k);
    endcase
  endfunction

  function automatic obs_t m_obs(input int k);
    obs_t o;
    o.hx = mx[k][0]; o.hy = my[k][0]; o.len = mlen[k];
    o.run = (mst[k] == 1) ? 1 : 0; o.dead = (mst[k] == 2) ? 1 : 0;
    o.wh = mwh[k]; o.sh = msh[k]; o.rdx = mrdx[k]; o.rdy = mrdy[k]; o.rdv = mrdv[k];
    return o;
  endfunction

  function automatic obs_t act(input int k);
    obs_t o;
    if (k == 0) begin
      o.hx = hx0; o.hy = hy0; o.len = len0; o.run = run0; o.dead = dead0;
      o.wh = wh0; o.sh = sh0; o.rdx = rdx0; o.rdy = rdy0; o.rdv = rdv0;
    end else begin
      o.hx = hx1; o.hy = hy1; o.len = len1; o.run = run1; o.dead = dead1;
      o.wh = wh1; o.sh = sh1; o.rdx = rdx1; o.rdy = rdy1; o.rdv = rdv1;
    end
    return o;
  endfunction

  task automatic chk(input string nm, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, a, e);
    end
  endtask

  task automatic cmp_obs(input int k, input obs_t e, input obs_t a);
    string p;
    p = $sformatf("u%0d.", k);
    chk({p, "head_x"}, a.hx, e.hx);    chk({p, "head_y"}, a.hy, e.hy);
    chk({p, "length"}, a.len, e.len);  chk({p, "running"}, a.run, e.run);
    chk({p, "dead"}, a.dead, e.dead);  chk({p, "wall_hit"}, a.wh, e.wh);
    chk({p, "self_hit"}, a.sh, e.sh);  chk({p, "rd_x"}, a.rdx, e.rdx);
    chk({p, "rd_y"}, a.rdy, e.rdy);    chk({p, "rd_valid"}, a.rdv, e.rdv);
  endtask

  // Monitor: every cycle the outputs are live; compare against queued expectations.
  initial begin
    forever begin
      @(posedge Clock);
      #1;
      if (exp_q0.size() > 0) cmp_obs(0, exp_q0.pop_front(), act(0));
      if (exp_q1.size() > 0) cmp_obs(1, exp_q1.pop_front(), act(1));
    end
  end

  task automatic cyc(input bit s, input bit st, input int d, input bit g, input int ri = -1);
    int r;
    @(negedge Clock);
    r = (ri < 0) ? int'($urandom_range(0, ML - 1)) : ri;
    start = s; step = st; dir = 2'(d); grow = g; rd_idx = 4'(r);
    @(posedge Clock);
    m_edge(0, 1'b0, s, st, d, g, r);
    m_edge(1, 1'b1, s, st, d, g, r);
    exp_q0.push_back(m_obs(0));
    exp_q1.push_back(m_obs(1));
  endtask

  // Assert reset in the middle of a step cycle; outputs must take reset values at once.
  task automatic do_reset();
    @(negedge Clock);
    step = 1'b1; start = 1'b0; grow = 1'b0;
    #2 Resetn = 1'b0;
    #1;
    m_reset(0); m_reset(1);
    cmp_obs(0, m_obs(0), act(0));
    cmp_obs(1, m_obs(1), act(1));
    @(posedge Clock);
    exp_q0.push_back(m_obs(0));
    exp_q1.push_back(m_obs(1));
    #3;
    Resetn = 1'b1; step = 1'b0;
  endtask

  initial begin
    m_reset(0); m_reset(1);
    do_reset();

    // Start and three moves right.
    cyc(0, 0, 0, 0); cyc(1, 0, 0, 0);
    repeat (3) cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0, 2);
    #1;
    chk("plan3 head_x", hx0, 83); chk("plan3 length", len0, 3);
    chk("plan3 running", run0, 1); chk("plan3 seg2_x", rdx0, 81); chk("plan3 seg2_y", rdy0, 60);

    // Reversal request is ignored.
    cyc(0, 0, 1, 0); cyc(0, 1, 1, 0);
    #1 chk("reversal head_x", hx0, 84);

    // Growth up to the cap.
    repeat (14) cyc(0, 1, 0, 1);
    #1 chk("cap length", len0, 16);
    cyc(0, 1, 0, 0);
    #1 chk("cap after length", len0, 16);

    // Run to the right edge: wall on u0, wrap on u1.
    repeat (60) cyc(0, 1, 0, 0);
    #1 chk("edge head_x", hx0, 159);
    cyc(0, 1, 0, 0);
    #1;
    chk("wall wall_hit", wh0, 1); chk("wall dead", dead0, 1); chk("wall head_x", hx0, 159);
    chk("wrap head_x", hx1, 0); chk("wrap running", run1, 1);
    cyc(0, 1, 0, 0);
    #1 chk("dead step head_x", hx0, 159);
    cyc(1, 0, 0, 0);
    #1;
    chk("restart length", len0, 3); chk("restart wall_hit", wh0, 0);
    chk("restart dead", dead0, 0); chk("restart running", run0, 0);

    // Wrap through x=0 leftwards and y=119 downwards.
    do_reset();
    cyc(1, 0, 0, 0);
    cyc(0, 0, 3, 0); cyc(0, 1, 3, 0);
    cyc(0, 0, 1, 0);
    repeat (80) cyc(0, 1, 1, 0);
    #1 chk("left edge head_x", hx1, 0);
    cyc(0, 1, 1, 0);
    #1;
    chk("wrapL head_x", hx1, 159); chk("wrapL wall_hit", wh1, 0); chk("wallL wall_hit", wh0, 1);
    cyc(0, 0, 2, 0);
    repeat (60) cyc(0, 1, 2, 0);
    #1 chk("bottom head_y", hy1, 119);
    cyc(0, 1, 2, 0);
    #1 chk("wrapD head_y", hy1, 0);

    // Self hit into seg[3] at length 5.
    do_reset();
    cyc(1, 0, 0, 0);
    repeat (2) cyc(0, 1, 0, 1);
    cyc(0, 0, 2, 0); cyc(0, 1, 2, 0);
    cyc(0, 0, 1, 0); cyc(0, 1, 1, 0);
    cyc(0, 0, 3, 0); cyc(0, 1, 3, 0);
    #1;
    chk("self self_hit", sh0, 1); chk("self dead", dead0, 1);
    chk("self length", len0, 5); chk("self head_x", hx0, 81);

    // Moving into the vacating tail cell is legal.
    do_reset();
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 1);
    cyc(0, 0, 2, 0); cyc(0, 1, 2, 0);
    cyc(0, 0, 1, 0); cyc(0, 1, 1, 0);
    cyc(0, 0, 3, 0); cyc(0, 1, 3, 0);
    #1;
    chk("tail self_hit", sh0, 0); chk("tail running", run0, 1);
    chk("tail head_x", hx0, 80); chk("tail head_y", hy0, 60);

    // Randomised play with periodic resets.
    for (int blk = 0; blk < 4; blk++) begin
      do_reset();
      cyc(1, 0, 0, 0);
      for (int n = 0; n < 600; n++)
        cyc($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1,
            int'($urandom_range(0, 3)), $urandom_range(0, 7) == 0);
    end

    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/snake_body_tracker.md
# snake_body_tracker

Parametrised snake body store and mover for the Snake game datapath. It holds up to MAX_LEN (x,y) segment coordinates, advances the head one cell per step pulse in the commanded direction, and grows on request. It detects wall and self collisions and exposes an indexed read port for the VGA drawing FSM. It replaces the fixed-length, separate-X/Y shift registers and the free-running head counters.

## Interface
Parameters:
- XW, 8, x coordinate width
- YW, 7, y coordinate width
- MAX_LEN, 16, maximum segment count (≥ INIT_LEN+1)
- INIT_LEN, 3, length after reset/restart
- X_MAX, 159, largest legal x
- Y_MAX, 119, largest legal y
- X0, 80, reset head x (≥ INIT_LEN-1)
- Y0, 60, reset head y
- WRAP, 0, 1: edges wrap around; 0: leaving the field is a wall hit

Ports:
- Clock  in  1  system clock (CLOCK_50)
- Resetn  in  1  asynchronous, active-low reset
- start  in  1  pulse; IDLE→RUN, or DEAD→reinitialise→IDLE
- step  in  1  one-cycle move strobe (from the slow-rate divider)
- dir  in  2  requested direction: 0 right, 1 left, 2 down, 3 up
- grow  in  1  pulse; add one segment on the next move
- head_x / head_y  out  XW / YW  segment 0
- length  out  $clog2(MAX_LEN+1)  current segment count
- rd_idx  in  $clog2(MAX_LEN)  read index
- rd_x / rd_y / rd_valid  out  XW / YW / 1  registered read of segment rd_idx; valid = rd_idx < length
- running  out  1  state == RUN
- dead  out  1  state == DEAD
- wall_hit / self_hit  out  1  sticky cause flags, cleared on restart

## Operation
- States: IDLE, RUN, DEAD. Reset → IDLE. IDLE: start → RUN. RUN: collision on a move → DEAD. DEAD: start → reinitialise body, go to IDLE.
- Reset/reinitialise: seg[i] = (X0-i, Y0) for i < INIT_LEN; other segments = 0. length = INIT_LEN. Current dir = right. grow_pend, flags, rd_* = 0.
- dir is latched every cycle in RUN, except for the exact reversal of the current dir (right↔left, up↔down), which is ignored.
- grow sets grow_pend in any state except DEAD. A move consumes grow_pend.
- Move (step while RUN): nh = head + unit vector of current dir.
  - WRAP=1: x wraps X_MAX↔0 and y wraps Y_MAX↔0.
  - WRAP=0: stepping past 0 or past the MAX value is a wall hit.
- Self hit: nh equals seg[i] for i < length, excluding seg[length-1] when not growing (the tail vacates that cell).
- On a hit: body, length and head stay unchanged; the flag is set; state goes to DEAD.
- Otherwise: seg[0] ← nh and seg[i] ← seg[i-1] for all i. If grow_pend and length < MAX_LEN, length increments. At MAX_LEN, growth is dropped silently and grow_pend still clears.
- step in IDLE or DEAD is ignored. start in RUN is ignored.
- grow and step in the same cycle: this move grows.
- Width: all coordinate arithmetic is done one bit wider to detect underflow/overflow before truncation.

## Timing
- All state updates on posedge Clock. Resetn asserts asynchronously at any time, including mid-move, and forces the reset values immediately.
- step → head_x/head_y/length/flags/dead are valid the cycle after the sampling edge (latency 1).
- The read port has latency 1: rd_x/rd_y/rd_valid reflect rd_idx and the body contents as of the previous edge. A read in the same cycle as a move returns the pre-move segment.
- Back-to-back step pulses (every cycle) are legal. Each step moves one cell.

## Structure
- Shared package snake_pkg holds the direction codes (DIR_RIGHT/LEFT/DOWN/UP) and the state encoding. The game FSM and the keyboard decoder also use it.
- Sub-module snake_next_head: combinational; takes head, dir and WRAP/limits; returns nh and wall flag. It is reused by the food-placement checker.
- Body storage is a register array, not RAM, because the collision compare needs all entries in parallel.

## Test plan
- Reset, then start, then 3 steps with dir=0 (defaults X0=80, Y0=60) → head (83,60), seg[2] = (81,60), length 3, running=1.
- From head (83,60) facing right: dir=1 then step → reversal ignored, head (84,60).
- grow and step in the same cycle, repeated 14 times → length caps at 16. The 14th growth is dropped and grow_pend is cleared.
- WRAP=0, head x=159, dir=0, step → wall_hit=1, dead=1, head stays (159,y). A further step changes nothing. start → IDLE, length 3, flags 0.
- WRAP=1, head (0,60), dir=1, step → head (159,60), no hit. Moving down from y=119 → y=0.
- Length 5, steering down/left/up into seg[3] → self_hit=1. Moving into the tail cell without growth → no hit. Also: assert Resetn low mid-step and confirm the reset values on the same cycle.
